// File: rtl/serdes_tx_word_scheduler.sv
// Word-slot scheduler feeding the TX serializer. Each slot is P_WIDTH cycles
// long and carries one word: a SKP ordered set when one is owed, otherwise a
// round-robin data grant, otherwise the IDLE filler.
module serdes_tx_word_scheduler #(
    parameter int                 P_WIDTH      = 130,
    parameter int                 NUM_REQ      = 2,
    parameter int                 SKP_INTERVAL = 370,
    parameter logic [P_WIDTH-1:0] IDLE_WORD    = {2'b01, 128'h0},
    parameter logic [P_WIDTH-1:0] SKP_WORD     = {2'b10, {16{8'hAA}}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*P_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [P_WIDTH-1:0]         parallel_out,
    output logic                       tx_valid_out,
    output logic                       word_strobe,
    output logic [1:0]                 sched_src,
    output logic                       skp_pending
);

    localparam int SLOT_W = $clog2(P_WIDTH);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1    = PTR_W + 1;
    localparam int SKP_W  = $clog2(SKP_INTERVAL + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(P_WIDTH - 1);
    localparam logic [SKP_W-1:0]  SKP_MAX   = SKP_W'(SKP_INTERVAL);
    localparam logic [PW1-1:0]    NREQ      = PW1'(NUM_REQ);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] SRC_IDLE = 2'd0;
    localparam logic [1:0] SRC_DATA = 2'd1;
    localparam logic [1:0] SRC_SKP  = 2'd2;

    typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [SKP_W-1:0]     skp_q, skp_d;
    logic [P_WIDTH-1:0]   word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 strobe_q, strobe_d;
    logic [1:0]           src_q, src_d;

    logic                 slot_end;
    logic                 boundary;
    logic                 skp_due;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [PW1-1:0]       gnt_sum;
    logic [PTR_W-1:0]     gnt_ptr;
    logic [PTR_W-1:0]     rr_next;
    logic [P_WIDTH-1:0]   sel_data;

    // A boundary is the cycle in which the next word is chosen. Gated by
    // rst_n so no accept pulse can escape while the block is held in reset.
    assign slot_end = (state_q == ST_RUN) && (slot_q == SLOT_LAST);
    assign boundary = rst_n && tx_en && ((state_q == ST_OFF) || slot_end);
    assign skp_due  = (skp_q == SKP_MAX);

    // Round-robin search: rotate valids so rr_q lands on bit 0, take the
    // lowest set bit, then rotate the index back.
    always_comb begin
        rot     = NUM_REQ'({req_valid, req_valid} >> rr_q);
        found   = 1'b0;
        gnt_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found   = 1'b1;
                gnt_sum = PW1'(k);
            end
        end
        gnt_sum = gnt_sum + {1'b0, rr_q};
        if (gnt_sum >= NREQ) gnt_sum = gnt_sum - NREQ;
        gnt_ptr = gnt_sum[PTR_W-1:0];
        rr_next = (gnt_ptr == PTR_LAST) ? '0 : gnt_ptr + 1'b1;
    end

    // Data mux for the granted requester.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_ptr == PTR_W'(i)) sel_data = req_data[i*P_WIDTH +: P_WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_OFF;
        else        state_q <= state_d;
    end

    // Next state: tx_en only matters on a boundary or at the end of a slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  if (boundary) state_d = ST_RUN;
            ST_RUN:  if (slot_end && !tx_en) state_d = ST_OFF;
            default: state_d = ST_OFF;
        endcase
    end

    // Accept pulse: one-hot, only on a boundary that is not spent on SKP.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = boundary && !skp_due && found && (gnt_ptr == PTR_W'(i));
        end
    end

    // Slot counter, word load and scheduling bookkeeping.
    always_comb begin
        slot_d   = slot_q;
        rr_d     = rr_q;
        skp_d    = skp_q;
        word_d   = word_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        src_d    = src_q;
        if (boundary) begin
            slot_d   = '0;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
            if (skp_due) begin
                word_d = SKP_WORD;
                src_d  = SRC_SKP;
                skp_d  = '0;
            end else if (found) begin
                word_d = sel_data;
                src_d  = SRC_DATA;
                rr_d   = rr_next;
                skp_d  = skp_q + 1'b1;
            end else begin
                word_d = IDLE_WORD;
                src_d  = SRC_IDLE;
                skp_d  = skp_q + 1'b1;
            end
        end else if (slot_end) begin
            // Last word finished with tx_en low: stream goes quiet.
            slot_d  = '0;
            valid_d = 1'b0;
            src_d   = SRC_IDLE;
            word_d  = '0;
        end else if (state_q == ST_RUN) begin
            slot_d = slot_q + 1'b1;
        end
    end

    // Datapath registers; rr_q and skp_q survive OFF and clear only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            rr_q     <= '0;
            skp_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            src_q    <= SRC_IDLE;
        end else begin
            slot_q   <= slot_d;
            rr_q     <= rr_d;
            skp_q    <= skp_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            src_q    <= src_d;
        end
    end

    assign parallel_out = word_q;
    assign tx_valid_out = valid_q;
    assign word_strobe  = strobe_q;
    assign sched_src    = src_q;
    assign skp_pending  = skp_due;

endmodule
